seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
Multi-cycle, parametrised add/subtract unit for the calculator datapath. It processes a WIDTH-bit operand pair SLICE_W bits per cycle, LSB slice first, through a ripple slice adder built from full-adder cells, with a registered carry between slices. A start/busy/done handshake lets the calculator control FSM issue operations and collect the result, carry and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE_W (elaboration error otherwise).
- SLICE_W, 4, bits processed per cycle; NUM_SLICES = WIDTH/SLICE_W.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start request; honoured only when not busy.
- i_sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
- i_a  in  WIDTH  operand A; captured on accepted start.
- i_b  in  WIDTH  operand B; captured on accepted start.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse when the result is valid.
- o_result  out  WIDTH  sum/difference; held until the next accepted start.
- o_carry  out  1  carry out of MSB (for subtract, 1 = no borrow).
- o_overflow  out  1  signed two's-complement overflow.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state = IDLE; o_busy, o_done, o_result, o_carry, o_overflow all 0; slice index 0. Reset asserted mid-RUN aborts the operation with no o_done.
- IDLE/DONE + i_start=1: capture A, B' = i_sub ? ~i_b : i_b, carry_in = i_sub, slice index = 0, clear o_result/o_carry/o_overflow; go to RUN. o_done is 0 the cycle after acceptance.
- DONE + i_start=0 → IDLE. DONE lasts exactly one cycle; o_done = 1 only in DONE.
- RUN: each cycle add slice k of A and B' plus the registered carry. Write the sum into bits [k*SLICE_W +: SLICE_W] of the result register and register the carry out. On the last slice (k = NUM_SLICES-1): o_carry = final carry, o_overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), then go to DONE.
- i_start while in RUN is ignored; operands are not re-sampled.
- Latency: start accepted at edge 0 → o_done high during cycle NUM_SLICES+1 (cycle 5 for defaults). Back-to-back: start asserted in DONE is accepted, giving one result every NUM_SLICES+1 cycles.
- Modular arithmetic: results wrap modulo 2^WIDTH; no width extension.
- o_result is registered and may show partial slices during RUN; it is valid only when o_done=1 and afterwards until the next accept.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: on the final slice, if overflow is detected, o_result clamps to the most-positive value (0x7FFF for WIDTH=16) when A[MSB]=0, or the most-negative value (0x8000) when A[MSB]=1. o_overflow still reports 1; o_carry is unchanged.
- Undefined: result wraps; no clamp logic is generated.

Decomposition:
- Shared package calc_pkg: state enum (IDLE, RUN, DONE) and a localparam helper for NUM_SLICES / slice-index width ($clog2).
- One sub-module, slice_adder (parameter SLICE_W): purely combinational ripple of full-adder cells with inputs a, b, cin and outputs sum, cout. All sequencing stays in seq_addsub.

Test Plan:
- Add 0x1234+0x4321, i_sub=0 → o_done exactly 5 cycles after accept; o_result=0x5555, o_carry=0, o_overflow=0; o_busy high for 4 cycles.
- Add 0xFFFF+0x0001 → 0x0000, carry=1, overflow=0. Add 0x7FFF+0x0001 → 0x8000, overflow=1 (ADDSUB_SATURATE_EN: 0x7FFF).
- Sub 0x0005-0x0007 → 0xFFFE, carry=0, overflow=0. Sub 0x8000-0x0001 → 0x7FFF, overflow=1 (ADDSUB_SATURATE_EN: 0x8000).
- Pulse i_start with new operands during RUN → ignored; first result unchanged. Then start in the DONE cycle → accepted; second o_done arrives 5 cycles later.
- Assert i_reset in RUN cycle 2 → next cycle IDLE with all outputs 0; no o_done; a fresh start afterwards completes correctly.
- Parameter sweep WIDTH=8/SLICE_W=8 and WIDTH=32/SLICE_W=1 → random add/sub results match a reference model; latency = NUM_SLICES+1.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared FSM state encoding and slice-count helpers for seq_addsub.
// Config   : ADDSUB_SATURATE_EN (consumed by seq_addsub)
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width, input int slice_w);
    return width / slice_w;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/seq_addsub_slice_adder.sv
`default_nettype none
// ============================================================================
// Module   : slice_adder
// Brief    : Combinational SLICE_W-bit ripple adder built from full-adder cells.
// Revision : 1.0 - initial release
// ============================================================================
module slice_adder #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[SLICE_W];

endmodule : slice_adder
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub
// Brief    : Multi-cycle add/subtract unit, SLICE_W bits per cycle, LSB first,
//            with start/busy/done handshake and carry/overflow flags.
// Config   : `define ADDSUB_SATURATE_EN to clamp signed overflow results.
// Revision : 1.0 - initial release
// ============================================================================
module seq_addsub
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int NUM_SLICES = num_slices(WIDTH, SLICE_W);
  localparam int IDX_W      = idx_width(NUM_SLICES);

  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("seq_addsub: WIDTH (%0d) must be a multiple of SLICE_W (%0d)", WIDTH, SLICE_W);
  end

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;      // already inverted for subtract
  logic               cin_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_d;
  logic               carry_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] sum_w;
  logic               cout_w;
  logic               last_w;
  logic               ovf_w;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_sl = a_q[k*SLICE_W +: SLICE_W];
        b_sl = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  slice_adder #(
    .SLICE_W (SLICE_W)
  ) u_slice_adder (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (cin_q),
    .sum  (sum_w),
    .cout (cout_w)
  );

  assign last_w = (idx_q == IDX_W'(NUM_SLICES - 1));
  // On the final slice the slice MSBs are the operand/result sign bits.
  assign ovf_w  = (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                  (sum_w[SLICE_W-1] != a_sl[SLICE_W-1]);

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_comb begin
    result_d = result_q;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        result_d[k*SLICE_W +: SLICE_W] = sum_w;
      end
    end
`ifdef ADDSUB_SATURATE_EN
    if (last_w && ovf_w) begin
      result_d = a_sl[SLICE_W-1] ? SAT_NEG : SAT_POS;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (i_start) begin
            a_q      <= i_a;
            b_q      <= i_sub ? ~i_b : i_b;
            cin_q    <= i_sub;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          result_q <= result_d;
          cin_q    <= cout_w;
          if (last_w) begin
            carry_q <= cout_w;
            ovf_q   <= ovf_w;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;

endmodule : seq_addsub
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_addsub
// Brief    : Self-checking bench for seq_addsub (16/4, 8/8 and 32/1 builds).
// Config   : honours ADDSUB_SATURATE_EN in its expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_addsub;

  typedef struct packed {
    logic [31:0] res;
    logic        cy;
    logic        ov;
  } exp_t;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [15:0] E_ADD_OVF = 16'h7FFF;
  localparam logic [15:0] E_SUB_OVF = 16'h8000;
`else
  localparam logic [15:0] E_ADD_OVF = 16'h8000;
  localparam logic [15:0] E_SUB_OVF = 16'h7FFF;
`endif

  logic        clk;
  logic        rst;
  logic        m_start, m_sub, m_busy, m_done, m_cy, m_ov;
  logic [15:0] m_a, m_b, m_res;
  logic        s_start, s_sub;
  logic [31:0] s_a, s_b;
  logic        s1_busy, s1_done, s1_cy, s1_ov;
  logic [7:0]  s1_res;
  logic        s2_busy, s2_done, s2_cy, s2_ov;
  logic [31:0] s2_res;

  int   nvec = 0;
  int   nerr = 0;
  exp_t qm[$];
  exp_t q1[$];
  exp_t q2[$];

  seq_addsub #(.WIDTH(16), .SLICE_W(4)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(m_start), .i_sub(m_sub),
    .i_a(m_a), .i_b(m_b), .o_busy(m_busy), .o_done(m_done),
    .o_result(m_res), .o_carry(m_cy), .o_overflow(m_ov)
  );

  seq_addsub #(.WIDTH(8), .SLICE_W(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_sub(s_sub),
    .i_a(s_a[7:0]), .i_b(s_b[7:0]), .o_busy(s1_busy), .o_done(s1_done),
    .o_result(s1_res), .o_carry(s1_cy), .o_overflow(s1_ov)
  );

  seq_addsub #(.WIDTH(32), .SLICE_W(1)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_sub(s_sub),
    .i_a(s_a), .i_b(s_b), .o_busy(s2_busy), .o_done(s2_done),
    .o_result(s2_res), .o_carry(s2_cy), .o_overflow(s2_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: w-bit add/sub with carry and signed overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input int w);
    logic [32:0] mask, bp, full;
    logic        am, bm, rm;
    exp_t        e;
    mask  = (33'd1 << w) - 33'd1;
    bp    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full  = ({1'b0, a} & mask) + bp + {32'd0, sub};
    e.res = 32'(full & mask);
    e.cy  = full[w];
    am    = a[w-1];
    bm    = bp[w-1];
    rm    = full[w-1];
    e.ov  = (am == bm) && (rm != am);
`ifdef ADDSUB_SATURATE_EN
    if (e.ov) e.res = am ? 32'(33'd1 << (w - 1)) : 32'(mask >> 1);
`endif
    return e;
  endfunction

  task automatic m_issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] er, input logic ec, input logic eo, input bit push);
    exp_t e;
    e.res = {16'd0, er};
    e.cy  = ec;
    e.ov  = eo;
    m_a = a; m_b = b; m_sub = sub; m_start = 1'b1;
    if (push) qm.push_back(e);
    tick();
    m_start = 1'b0;
    check("accept_busy", 32'(m_busy), 32'd1);
    check("accept_done", 32'(m_done), 32'd0);
  endtask

  // Entered one cycle after the accepting edge; returns in the DONE cycle.
  task automatic m_wait(input string tag, input bit inj);
    int   cyc  = 1;
    int   bcnt = 0;
    exp_t e;
    while (m_done !== 1'b1 && cyc <= 20) begin
      if (m_busy) bcnt++;
      if (inj && cyc == 2) begin
        m_start = 1'b1; m_a = 16'hDEAD; m_b = 16'hBEEF; m_sub = 1'b1;
      end
      if (inj && cyc == 3) m_start = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_done"}, 32'(m_done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_busycycles"}, 32'(bcnt), 32'd4);
    check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
    check({tag, "_sb_nonempty"}, 32'(qm.size() > 0), 32'd1);
    if (qm.size() > 0) begin
      e = qm.pop_front();
      check({tag, "_result"}, {16'd0, m_res}, e.res);
      check({tag, "_carry"}, 32'(m_cy), 32'(e.cy));
      check({tag, "_overflow"}, 32'(m_ov), 32'(e.ov));
    end
  endtask

  task automatic sw_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int   cyc = 1;
    bit   got1 = 0;
    bit   got2 = 0;
    exp_t e;
    q1.push_back(model(a, b, sub, 8));
    q2.push_back(model(a, b, sub, 32));
    s_a = a; s_b = b; s_sub = sub; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    while (!(got1 && got2) && cyc <= 45) begin
      if (!got1 && s1_done === 1'b1) begin
        got1 = 1;
        e = q1.pop_front();
        check("sw8_latency", 32'(cyc), 32'd2);
        check("sw8_result", {24'd0, s1_res}, e.res);
        check("sw8_flags", {30'd0, s1_cy, s1_ov}, {30'd0, e.cy, e.ov});
      end
      if (!got2 && s2_done === 1'b1) begin
        got2 = 1;
        e = q2.pop_front();
        check("sw32_latency", 32'(cyc), 32'd33);
        check("sw32_result", s2_res, e.res);
        check("sw32_flags", {30'd0, s2_cy, s2_ov}, {30'd0, e.cy, e.ov});
      end
      tick();
      cyc++;
    end
    check("sw8_seen", 32'(got1), 32'd1);
    check("sw32_seen", 32'(got2), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    m_start = 1'b0; m_sub = 1'b0; m_a = '0; m_b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
    repeat (3) tick();
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_result", {16'd0, m_res}, 32'd0);
    check("rst_flags", {30'd0, m_cy, m_ov}, 32'd0);
    check("rst_sweep", {28'd0, s1_busy, s1_done, s2_busy, s2_done}, 32'd0);
    rst = 1'b0;
    tick();

    m_issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    m_wait("add_basic", 1'b0);
    tick();
    check("idle_after_done", 32'(m_done), 32'd0);

    m_issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    m_wait("add_wrap", 1'b0);
    tick();
    m_issue(16'h7FFF, 16'h0001, 1'b0, E_ADD_OVF, 1'b0, 1'b1, 1'b1);
    m_wait("add_ovf", 1'b0);
    tick();
    m_issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    m_wait("sub_borrow", 1'b0);
    tick();
    m_issue(16'h8000, 16'h0001, 1'b1, E_SUB_OVF, 1'b1, 1'b1, 1'b1);
    m_wait("sub_ovf", 1'b0);
    tick();

    // Start pulsed mid-run is ignored; start in DONE is accepted back-to-back.
    m_issue(16'h0100, 16'h0011, 1'b0, 16'h0111, 1'b0, 1'b0, 1'b1);
    m_wait("run_ignore", 1'b1);
    m_issue(16'h00F0, 16'h0010, 1'b1, 16'h00E0, 1'b1, 1'b0, 1'b1);
    m_wait("back2back", 1'b0);
    tick();
    check("b2b_idle_busy", 32'(m_busy), 32'd0);
    check("b2b_idle_done", 32'(m_done), 32'd0);

    // Reset during the second RUN cycle aborts with no done pulse.
    m_issue(16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_done", 32'(m_done), 32'd0);
    check("abort_result", {16'd0, m_res}, 32'd0);
    check("abort_flags", {30'd0, m_cy, m_ov}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_done === 1'b1 || m_busy === 1'b1) seen = 1;
      tick();
    end
    check("abort_quiet", 32'(seen), 32'd0);
    m_issue(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    m_wait("post_reset", 1'b0);
    tick();

    sw_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    sw_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    sw_op(32'h0000_007F, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sw_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_seq_addsub
`default_nettype wire
